// File: rtl/axon_arbiter_pkg.sv
// Shared node package for the axon arbiter.
// Holds the packet type codes and the arbiter FSM encoding.
package axon_arbiter_pkg;

    localparam logic [2:0] PT_SPIKE    = 3'b000;
    localparam logic [2:0] PT_DATA     = 3'b001;
    localparam logic [2:0] PT_DATA_END = 3'b010;
    localparam logic [2:0] PT_WRITE    = 3'b110;
    localparam logic [2:0] PT_READ     = 3'b111;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/spk_fifo.sv
// Per-requester packet FIFO holding {type,data} entries.
// A push on a full FIFO is refused even when a pop happens in the same cycle.
module spk_fifo #(
    parameter int W     = 27,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/axon_arbiter.sv
// Two-requester round-robin arbiter feeding one axon port.
// A DATA grant locks the axon to its owner until the matching DATA_END.
module axon_arbiter
    import axon_arbiter_pkg::*;
#(
    parameter int SW    = 24,
    parameter int FTW   = 3,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_vld,
    input  logic [SW-1:0]  req0_data,
    input  logic [FTW-1:0] req0_type,
    output logic           req0_rdy,
    input  logic           req1_vld,
    input  logic [SW-1:0]  req1_data,
    input  logic [FTW-1:0] req1_type,
    output logic           req1_rdy,
    input  logic           axon_busy,
    output logic           spk_in_axon_vld,
    output logic [SW-1:0]  spk_in_axon_data,
    output logic [FTW-1:0] spk_in_axon_type,
    output logic           err_sticky
);

    localparam int PW = SW + FTW;
    localparam logic [FTW-1:0] T_DATA     = FTW'(PT_DATA);
    localparam logic [FTW-1:0] T_DATA_END = FTW'(PT_DATA_END);

    arb_state_e     state;
    logic           rr;
    logic           owner;
    logic [PW-1:0]  head0;
    logic [PW-1:0]  head1;
    logic           full0;
    logic           full1;
    logic           empty0;
    logic           empty1;
    logic           grant;
    logic           sel;
    logic           pop0;
    logic           pop1;
    logic [PW-1:0]  pkt;
    logic [FTW-1:0] ptype;
    logic [SW-1:0]  pdata;

    spk_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req0_vld),
        .wdata ({req0_type, req0_data}),
        .pop   (pop0),
        .rdata (head0),
        .full  (full0),
        .empty (empty0)
    );

    spk_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req1_vld),
        .wdata ({req1_type, req1_data}),
        .pop   (pop1),
        .rdata (head1),
        .full  (full1),
        .empty (empty1)
    );

    assign req0_rdy = !full0;
    assign req1_rdy = !full1;

    // Pick the source for this edge; rr wins only when it has something.
    always_comb begin
        grant = 1'b0;
        sel   = 1'b0;
        unique case (state)
            ARB: begin
                grant = !axon_busy && !(empty0 && empty1);
                if (rr) begin
                    sel = !empty1 ? 1'b1 : 1'b0;
                end else begin
                    sel = !empty0 ? 1'b0 : 1'b1;
                end
            end
            BURST: begin
                sel   = owner;
                grant = owner ? !empty1 : !empty0;
            end
            default: begin
                grant = 1'b0;
                sel   = 1'b0;
            end
        endcase
    end

    assign pop0  = grant && !sel;
    assign pop1  = grant && sel;
    assign pkt   = sel ? head1 : head0;
    assign ptype = pkt[PW-1:SW];
    assign pdata = pkt[SW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ARB;
            rr               <= 1'b0;
            owner            <= 1'b0;
            spk_in_axon_vld  <= 1'b0;
            spk_in_axon_data <= '0;
            spk_in_axon_type <= '0;
            err_sticky       <= 1'b0;
        end else begin
            spk_in_axon_vld <= 1'b0;
            if (grant) begin
                unique case (state)
                    ARB: begin
                        spk_in_axon_vld  <= 1'b1;
                        spk_in_axon_data <= pdata;
                        spk_in_axon_type <= ptype;
                        rr               <= !sel;
                        if (ptype == T_DATA) begin
                            owner <= sel;
                            state <= BURST;
                        end
                    end
                    BURST: begin
                        unique case (1'b1)
                            (ptype == T_DATA): begin
                                spk_in_axon_vld  <= 1'b1;
                                spk_in_axon_data <= pdata;
                                spk_in_axon_type <= ptype;
                            end
                            (ptype == T_DATA_END): begin
                                spk_in_axon_vld  <= 1'b1;
                                spk_in_axon_data <= pdata;
                                spk_in_axon_type <= ptype;
                                state            <= ARB;
                            end
                            default: begin
                                err_sticky <= 1'b1;
                            end
                        endcase
                    end
                    default: begin
                        state <= ARB;
                    end
                endcase
            end
        end
    end

endmodule
